// File: rtl/rsa_pkg.sv
// Shared widths and FSM encoding for the RSA byte-serial I/O controller.
package rsa_pkg;

    localparam int unsigned WORD_W = 256;
    localparam int unsigned NBYTES = WORD_W / 8;
    localparam int unsigned CNT_W  = $clog2(NBYTES);

    typedef enum logic [2:0] {
        ST_LOAD_N,
        ST_LOAD_E,
        ST_LOAD_M,
        ST_CHECK,
        ST_START,
        ST_WAIT,
        ST_SEND
    } state_e;

endpackage

// File: rtl/rsa_byte_packer.sv
// WORD_W operand register filled one byte lane at a time.
module rsa_byte_packer
    import rsa_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [CNT_W-1:0]  idx_i,
    input  logic [7:0]        byte_i,
    output logic [WORD_W-1:0] word_o
);

    logic [WORD_W-1:0] word_q, word_d;

    always_comb begin
        word_d = word_q;
        if (we_i) begin
            word_d[{idx_i, 3'b000} +: 8] = byte_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/rsa_io_ctrl.sv
// Byte-serial loader/unloader around the RSA modexp core: gathers N/E/M, starts the core,
// streams the result back out LSB first.
module rsa_io_ctrl
    import rsa_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    input  logic              abort,
    output logic [WORD_W-1:0] core_n,
    output logic [WORD_W-1:0] core_e,
    output logic [WORD_W-1:0] core_m,
    output logic              core_start,
    input  logic              core_done,
    input  logic [WORD_W-1:0] core_result,
    output logic              busy,
    output logic              err_even_mod
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] res_q, res_d;
    logic              err_q, err_d;

    logic in_xfer, out_xfer, last_byte;

    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign last_byte = (cnt_q == CNT_W'(NBYTES - 1));

    rsa_byte_packer u_pack_n (
        .clk_i  (clk),
        .rst_i  (reset),
        .we_i   (in_xfer && (state_q == ST_LOAD_N)),
        .idx_i  (cnt_q),
        .byte_i (in_data),
        .word_o (core_n)
    );

    rsa_byte_packer u_pack_e (
        .clk_i  (clk),
        .rst_i  (reset),
        .we_i   (in_xfer && (state_q == ST_LOAD_E)),
        .idx_i  (cnt_q),
        .byte_i (in_data),
        .word_o (core_e)
    );

    rsa_byte_packer u_pack_m (
        .clk_i  (clk),
        .rst_i  (reset),
        .we_i   (in_xfer && (state_q == ST_LOAD_M)),
        .idx_i  (cnt_q),
        .byte_i (in_data),
        .word_o (core_m)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        res_d      = res_q;
        err_d      = err_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        core_start = 1'b0;
        busy       = 1'b0;

        unique case (state_q)
            ST_LOAD_N, ST_LOAD_E, ST_LOAD_M: begin
                in_ready = !abort;
                if (in_xfer) begin
                    cnt_d = cnt_q + 1'b1;
                    if (state_q == ST_LOAD_N && cnt_q == '0) begin
                        err_d = 1'b0;
                    end
                    if (last_byte) begin
                        unique case (state_q)
                            ST_LOAD_N: state_d = ST_LOAD_E;
                            ST_LOAD_E: state_d = ST_LOAD_M;
                            default:   state_d = ST_CHECK;
                        endcase
                    end
                end
            end
            ST_CHECK: begin
                if (!core_n[0]) begin
                    err_d   = 1'b1;
                    state_d = ST_LOAD_N;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                busy       = 1'b1;
                core_start = !abort;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (core_done) begin
                    res_d   = core_result;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                busy      = 1'b1;
                out_valid = !abort;
                if (out_xfer) begin
                    res_d = res_q >> 8;
                    cnt_d = cnt_q + 1'b1;
                    if (last_byte) begin
                        state_d = ST_LOAD_N;
                    end
                end
            end
            default: state_d = ST_LOAD_N;
        endcase

        // Abort overrides any progress made above but leaves operands and the flag alone.
        if (abort) begin
            state_d = ST_LOAD_N;
            cnt_d   = '0;
            res_d   = res_q;
            err_d   = err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_LOAD_N;
            cnt_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    assign out_data     = res_q[7:0];
    assign err_even_mod = err_q;

endmodule

// File: tb/tb_rsa_io_ctrl.sv
// Directed bench for rsa_io_ctrl with a transaction-level reference model.
module tb_rsa_io_ctrl;
    import rsa_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0, in_ready;
    logic [7:0]        in_data = 8'h00;
    logic              out_valid, out_ready = 1'b0;
    logic [7:0]        out_data;
    logic              abort = 1'b0;
    logic [WORD_W-1:0] core_n, core_e, core_m;
    logic              core_start, core_done = 1'b0;
    logic [WORD_W-1:0] core_result = '0;
    logic              busy, err_even_mod;

    rsa_io_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .abort        (abort),
        .core_n       (core_n),
        .core_e       (core_e),
        .core_m       (core_m),
        .core_start   (core_start),
        .core_done    (core_done),
        .core_result  (core_result),
        .busy         (busy),
        .err_even_mod (err_even_mod)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0, last_acc = 0, starts = 0, start_cyc = 0;
    logic [WORD_W-1:0] st_n, st_e, st_m;

    task automatic chk(input string name, input logic [WORD_W-1:0] act,
                       input logic [WORD_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (core_start) begin
            starts++;
            start_cyc = cyc;
            st_n = core_n;
            st_e = core_e;
            st_m = core_m;
        end
    end

    // Reference model: phase 0 load, 1 check, 2 start, 3 wait, 4 send.
    int                m_ph = 0, m_in = 0, m_out = 0;
    logic [WORD_W-1:0] m_op [3];
    logic [WORD_W-1:0] m_res;
    logic              m_err;
    bit                m_ok = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_ph = 0; m_in = 0; m_out = 0; m_res = '0; m_err = 1'b0; m_ok = 1;
            for (int i = 0; i < 3; i++) m_op[i] = '0;
        end else if (m_ok) begin
            if (abort) begin
                m_ph = 0;
                m_in = 0;
            end else begin
                case (m_ph)
                    0: if (in_valid) begin
                        if (m_in == 0) m_err = 1'b0;
                        m_op[m_in / NBYTES][8 * (m_in % NBYTES) +: 8] = in_data;
                        m_in++;
                        if (m_in == 3 * NBYTES) begin
                            m_in = 0;
                            m_ph = 1;
                        end
                    end
                    1: if (m_op[0][0] == 1'b0) begin
                        m_err = 1'b1;
                        m_ph  = 0;
                    end else begin
                        m_ph = 2;
                    end
                    2: m_ph = 3;
                    3: if (core_done) begin
                        m_res = core_result;
                        m_out = 0;
                        m_ph  = 4;
                    end
                    default: if (out_ready) begin
                        m_out++;
                        if (m_out == NBYTES) m_ph = 0;
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok && !reset) begin
            chk("in_ready", in_ready, m_ph == 0 && !abort);
            chk("out_valid", out_valid, m_ph == 4 && !abort);
            chk("core_start", core_start, m_ph == 2 && !abort);
            chk("busy", busy, m_ph >= 2);
            chk("err_even_mod", err_even_mod, m_err);
            chk("core_n", core_n, m_op[0]);
            chk("core_e", core_e, m_op[1]);
            chk("core_m", core_m, m_op[2]);
            if (m_ph == 4) chk("out_data", out_data, m_res[8 * m_out +: 8]);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                last_acc = cyc;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        fail_now("send_byte");
    endtask

    task automatic load_word(input logic [WORD_W-1:0] w, input int first, input int maxgap);
        int g;
        for (int k = first; k < NBYTES; k++) begin
            send_byte(w[8 * k +: 8]);
            g = $urandom_range(maxgap, 0);
            if (g > 0) begin
                repeat (g) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic recv(input int stall_after, input int stall_len,
                        output logic [WORD_W-1:0] got);
        int k, t;
        k = 0;
        t = 0;
        got = '0;
        out_ready = 1'b1;
        while (k < NBYTES && t < 2000) begin
            @(negedge clk);
            t++;
            if (out_valid && out_ready) begin
                got[8 * k +: 8] = out_data;
                k++;
            end
            @(posedge clk);
            #1;
            if (k == stall_after && out_ready) begin
                out_ready = 1'b0;
                repeat (stall_len) @(posedge clk);
                #1;
                out_ready = 1'b1;
                stall_after = -1;
            end
        end
        out_ready = 1'b0;
        if (k < NBYTES) fail_now("recv");
    endtask

    task automatic pulse_done(input logic [WORD_W-1:0] r);
        core_result = r;
        core_done   = 1'b1;
        @(posedge clk);
        #1;
        core_done = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
    endtask

    logic [WORD_W-1:0] got, res2;
    logic [WORD_W-1:0] n2, e2, m2;
    int                s0;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst in_ready", in_ready, 1);
        chk("rst out_valid", out_valid, 0);
        chk("rst busy", busy, 0);
        chk("rst core_start", core_start, 0);
        chk("rst core_n", core_n, 0);
        chk("rst err", err_even_mod, 0);
        @(posedge clk);
        #1;

        // Full transaction N=7, E=4, M=3, core answers 4.
        s0 = starts;
        load_word(256'd7, 0, 0);
        load_word(256'd4, 0, 0);
        load_word(256'd3, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("start count", starts, s0 + 1);
        chk("start latency", start_cyc, last_acc + 2);
        chk("start n", st_n, 256'd7);
        chk("start e", st_e, 256'd4);
        chk("start m", st_m, 256'd3);
        pulse_done(256'd4);
        recv(-1, 0, got);
        chk("result bytes", got, 256'd4);
        @(negedge clk);
        chk("back to load", in_ready, 1);
        @(posedge clk);
        #1;

        // Even modulus is rejected without starting the core.
        s0 = starts;
        load_word(256'd8, 0, 0);
        load_word(256'd4, 0, 0);
        load_word(256'd3, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("even no start", starts, s0);
        @(negedge clk);
        chk("even err", err_even_mod, 1);
        chk("even in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Next load clears the flag on its first byte; random input gaps and output stall.
        n2 = {8{32'hDEADBEEF}};
        e2 = {8{32'h01234567}};
        m2 = {8{32'h89ABCDEF}};
        for (int k = 0; k < NBYTES; k++) res2[8 * k +: 8] = 8'hA0 ^ 8'(k);
        send_byte(n2[7:0]);
        @(negedge clk);
        chk("err cleared", err_even_mod, 0);
        @(posedge clk);
        #1;
        s0 = starts;
        load_word(n2, 1, 2);
        load_word(e2, 0, 2);
        load_word(m2, 0, 2);
        repeat (3) @(posedge clk);
        #1;
        chk("gap start count", starts, s0 + 1);
        chk("gap start n", st_n, n2);
        chk("gap start e", st_e, e2);
        chk("gap start m", st_m, m2);
        chk("pattern byte5", res2[47:40], 8'hA5);
        pulse_done(res2);
        recv(5, 10, got);
        chk("stalled result", got, res2);

        // Abort in LOAD_E at byte 10: next byte goes to core_n[7:0].
        load_word({32{8'h3D}}, 0, 0);
        for (int k = 0; k < 10; k++) send_byte(8'(k + 1));
        pulse_abort();
        send_byte(8'h55);
        @(negedge clk);
        chk("abort n lo", core_n[7:0], 8'h55);
        chk("abort n kept", core_n[15:8], 8'h3D);
        chk("abort e kept", core_e[7:0], 8'h01);
        @(posedge clk);
        #1;
        pulse_abort();

        // Stray done during LOAD_M is ignored; abort in WAIT then done gives no output.
        s0 = starts;
        load_word(256'd11, 0, 0);
        load_word(256'd2, 0, 0);
        for (int k = 0; k < NBYTES; k++) begin
            send_byte(k == 0 ? 8'd9 : 8'd0);
            if (k == 4) pulse_done(256'hFF);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("stray start count", starts, s0 + 1);
        chk("stray start m", st_m, 256'd9);
        pulse_abort();
        pulse_done(256'h1234);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("no out after abort", out_valid, 0);
        end
        chk("idle after abort", in_ready, 1);
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
